// File: rtl/mt9v034_pkg.sv
//==============================================================================
// Module   : mt9v034_pkg
// Purpose  : Shared constants for the MT9V034-style LVDS serializer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mt9v034_pkg;

    localparam int PIX_W    = 10;
    localparam int WORD_W   = PIX_W + 2;
    localparam int BITCNT_W = 4;
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(WORD_W - 1);

    localparam logic [PIX_W-1:0] SYNC_MARK = 10'h3FF;
    localparam logic [PIX_W-1:0] CODE_FS   = 10'h001;
    localparam logic [PIX_W-1:0] CODE_LS   = 10'h002;
    localparam logic [PIX_W-1:0] CODE_LE   = 10'h003;
    localparam logic [PIX_W-1:0] CODE_FE   = 10'h004;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_PRE_MARK  = 3'd1;
    localparam state_t ST_PRE_CODE  = 3'd2;
    localparam state_t ST_PIXEL     = 3'd3;
    localparam state_t ST_POST_MARK = 3'd4;
    localparam state_t ST_POST_CODE = 3'd5;

endpackage

`default_nettype wire

// File: rtl/mt9v034_word_shifter.sv
//==============================================================================
// Module   : mt9v034_word_shifter
// Purpose  : 12-bit load/shift register with bit counter; emits one bit/clock.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mt9v034_word_shifter
    import mt9v034_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_word,
    output logic              o_load,
    output logic              o_txd,
    output logic              o_word_start
);

    logic                r_run;
    logic [BITCNT_W-1:0] r_bitcnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_word_start;
    logic                w_load;

    // The very first edge after reset loads immediately so a start bit follows release.
    assign w_load = !r_run || (r_bitcnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run        <= 1'b0;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_word_start <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_word_start <= w_load;
            if (w_load) begin
                r_bitcnt <= '0;
                r_shift  <= i_word;
            end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
                r_shift  <= {1'b0, r_shift[DATA_W-1:1]};
            end
        end
    end

    assign o_load       = w_load;
    assign o_txd        = r_shift[0];
    assign o_word_start = r_word_start;

endmodule

`default_nettype wire

// File: rtl/mt9v034_lvds_serializer.sv
//==============================================================================
// Module   : mt9v034_lvds_serializer
// Purpose  : Pixel holding register, sync-code FSM and serial word framing.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mt9v034_lvds_serializer
    import mt9v034_pkg::*;
#(
    parameter int                      C_PixelWidth = 10,
    parameter int                      C_DataWidth  = 12,
    parameter logic [C_PixelWidth-1:0] C_IdleWord   = 10'h000
) (
    input  logic                    TxClk,
    input  logic                    TxReset_n,
    input  logic                    PixValid,
    output logic                    PixReady,
    input  logic [C_PixelWidth-1:0] PixData,
    input  logic                    PixFrameStart,
    input  logic                    PixLineStart,
    input  logic                    PixLineEnd,
    input  logic                    PixFrameEnd,
    output logic                    TxD,
    output logic                    TxWordStart,
    output logic                    TxBusy
);

    logic                    r_live;
    logic                    r_full;
    logic [C_PixelWidth-1:0] r_pix;
    logic                    r_fs;
    logic                    r_ls;
    logic                    r_le;
    logic                    r_fe;
    logic                    r_end_le;
    logic                    r_end_fe;
    state_t                  r_state;

    state_t                  w_decide;
    state_t                  w_sel;
    state_t                  w_next;
    logic [C_PixelWidth-1:0] w_payload;
    logic [C_PixelWidth-1:0] w_pix_clamped;
    logic [C_DataWidth-1:0]  w_word;
    logic                    w_load;
    logic                    w_accept;
    logic                    w_free;

    assign PixReady = r_live && !r_full;
    assign w_accept = PixValid && PixReady;

    // All-ones is reserved for sync marks, so real pixels top out one below it.
    assign w_pix_clamped = (r_pix == {C_PixelWidth{1'b1}})
                         ? {{(C_PixelWidth-1){1'b1}}, 1'b0} : r_pix;

    always_ff @(posedge TxClk or negedge TxReset_n) begin
        if (!TxReset_n) begin
            r_live   <= 1'b0;
            r_full   <= 1'b0;
            r_pix    <= '0;
            r_fs     <= 1'b0;
            r_ls     <= 1'b0;
            r_le     <= 1'b0;
            r_fe     <= 1'b0;
            r_end_le <= 1'b0;
            r_end_fe <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_full <= 1'b1;
                r_pix  <= PixData;
                r_fs   <= PixFrameStart;
                r_ls   <= PixLineStart;
                r_le   <= PixLineEnd;
                r_fe   <= PixFrameEnd;
            end else if (w_free) begin
                r_full <= 1'b0;
            end
            // End flags travel with the pixel on the line, not with the holding register.
            if (w_free) begin
                r_end_le <= r_le;
                r_end_fe <= r_fe;
            end
        end
    end

    always_ff @(posedge TxClk or negedge TxReset_n) begin
        if (!TxReset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_decide = ST_IDLE;
        if (r_full) begin
            w_decide = (r_fs || r_ls) ? ST_PRE_MARK : ST_PIXEL;
        end
        w_sel = ST_IDLE;
        case (r_state)
            ST_IDLE:      w_sel = w_decide;
            ST_PRE_MARK:  w_sel = ST_PRE_CODE;
            ST_PRE_CODE:  w_sel = ST_PIXEL;
            ST_PIXEL:     w_sel = (r_end_fe || r_end_le) ? ST_POST_MARK : w_decide;
            ST_POST_MARK: w_sel = ST_POST_CODE;
            ST_POST_CODE: w_sel = w_decide;
            default:      w_sel = ST_IDLE;
        endcase
        w_next = w_load ? w_sel : r_state;
    end

    always_comb begin
        w_payload = C_IdleWord;
        case (w_sel)
            ST_PRE_MARK,
            ST_POST_MARK: w_payload = SYNC_MARK;
            ST_PRE_CODE:  w_payload = r_fs ? CODE_FS : CODE_LS;
            ST_PIXEL:     w_payload = w_pix_clamped;
            ST_POST_CODE: w_payload = r_end_fe ? CODE_FE : CODE_LE;
            default:      w_payload = C_IdleWord;
        endcase
        w_free = w_load && (w_sel == ST_PIXEL);
    end

    assign w_word = {1'b0, w_payload, 1'b1};
    assign TxBusy = (r_state != ST_IDLE);

    mt9v034_word_shifter #(
        .DATA_W (C_DataWidth)
    ) u_shifter (
        .clk          (TxClk),
        .rst_n        (TxReset_n),
        .i_word       (w_word),
        .o_load       (w_load),
        .o_txd        (TxD),
        .o_word_start (TxWordStart)
    );

endmodule

`default_nettype wire

// File: tb/tb_mt9v034_lvds_serializer.sv
//==============================================================================
// Module   : tb_mt9v034_lvds_serializer
// Purpose  : Scoreboard bench with a serial deserializer and word-level model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mt9v034_lvds_serializer;

    localparam logic [9:0] IDLE = 10'h000;

    logic       TxClk = 1'b0;
    logic       TxReset_n;
    logic       PixValid;
    logic       PixReady;
    logic [9:0] PixData;
    logic       PixFrameStart, PixLineStart, PixLineEnd, PixFrameEnd;
    logic       TxD, TxWordStart, TxBusy;

    mt9v034_lvds_serializer dut (
        .TxClk         (TxClk),
        .TxReset_n     (TxReset_n),
        .PixValid      (PixValid),
        .PixReady      (PixReady),
        .PixData       (PixData),
        .PixFrameStart (PixFrameStart),
        .PixLineStart  (PixLineStart),
        .PixLineEnd    (PixLineEnd),
        .PixFrameEnd   (PixFrameEnd),
        .TxD           (TxD),
        .TxWordStart   (TxWordStart),
        .TxBusy        (TxBusy)
    );

    always #5 TxClk = ~TxClk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    always @(posedge TxClk) cyc <= cyc + 1;

    logic [9:0] sb[$];
    int         busy_cycles = 0;
    int         run_len = 0;
    int         max_run = 0;
    bit         synced = 0;
    int         pos = 0;
    bit         frame_ok;
    bit         busy_w;
    logic [9:0] pay;
    int         acc_cyc;
    int         acc_t[100];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Word-level model: optional start pair, clamped pixel, optional end pair.
    task automatic push_expected(input logic [9:0] p, input bit fs, ls, le, fe);
        if (fs || ls) begin
            sb.push_back(10'h3FF);
            sb.push_back(fs ? 10'h001 : 10'h002);
        end
        sb.push_back((p == 10'h3FF) ? 10'h3FE : p);
        if (fe || le) begin
            sb.push_back(10'h3FF);
            sb.push_back(fe ? 10'h004 : 10'h003);
        end
    endtask

    task automatic finish_word();
        logic [9:0] exp;
        chk("frame", frame_ok, 1);
        if (!busy_w) begin
            chk("idle_payload", pay, IDLE);
            if (run_len > max_run) max_run = run_len;
            run_len = 0;
        end else begin
            run_len++;
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_word actual=%0h required=none (t=%0t)", pay, $time);
            end else begin
                n_pass++;
                exp = sb.pop_front();
                chk("word", pay, exp);
            end
        end
    endtask

    // Deserializer: start bit, 10 payload bits LSB first, stop bit, then next start.
    initial begin : monitor
        forever begin
            @(negedge TxClk);
            if (TxBusy) busy_cycles++;
            if (!TxReset_n) begin
                synced = 0;
                continue;
            end
            if (!synced) begin
                if (TxWordStart) begin
                    synced = 1; pos = 0; frame_ok = TxD; busy_w = TxBusy; pay = '0;
                end
                continue;
            end
            pos++;
            if (pos == 12) begin
                pos = 0; frame_ok = TxWordStart && TxD; busy_w = TxBusy; pay = '0;
            end else begin
                if (TxWordStart) frame_ok = 0;
                if (pos <= 10) pay[pos-1] = TxD;
                else begin
                    if (TxD) frame_ok = 0;
                    finish_word();
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge TxClk);
        #1;
    endtask

    task automatic send_pixel(input logic [9:0] p, input bit fs, ls, le, fe);
        int t = 0;
        bit got = 0;
        @(negedge TxClk);
        PixValid = 1; PixData = p;
        PixFrameStart = fs; PixLineStart = ls; PixLineEnd = le; PixFrameEnd = fe;
        while (!got && t < 200) begin
            if (PixReady) begin
                @(posedge TxClk);
                got = 1;
                acc_cyc = cyc;
                push_expected(p, fs, ls, le, fe);
            end else begin
                @(negedge TxClk);
                t++;
            end
        end
        chk("accept", got, 1);
    endtask

    task automatic drop_valid();
        @(negedge TxClk);
        PixValid = 0;
        PixFrameStart = 0; PixLineStart = 0; PixLineEnd = 0; PixFrameEnd = 0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(negedge TxClk);
            t++;
        end
        chk("drain", sb.size(), 0);
        wait_cycles(30);
    endtask

    initial begin : stim
        bit found;
        TxReset_n = 0; PixValid = 0; PixData = '0;
        PixFrameStart = 0; PixLineStart = 0; PixLineEnd = 0; PixFrameEnd = 0;

        wait_cycles(3);
        chk("rst_txd", TxD, 0);
        chk("rst_wordstart", TxWordStart, 0);
        chk("rst_busy", TxBusy, 0);
        chk("rst_ready", PixReady, 0);
        TxReset_n = 1;
        @(posedge TxClk); #1;
        chk("rel_wordstart", TxWordStart, 1);
        chk("rel_txd", TxD, 1);
        chk("rel_ready", PixReady, 1);

        // Idle stream only.
        busy_cycles = 0;
        wait_cycles(60);
        chk("idle_busy_cycles", busy_cycles, 0);

        // Frame start + frame end on one pixel: five busy words.
        busy_cycles = 0; max_run = 0;
        send_pixel(10'h155, 1, 0, 0, 1);
        drop_valid();
        drain();
        chk("fsfe_busy_cycles", busy_cycles, 60);
        chk("fsfe_run_words", max_run, 5);

        // Reserved value clamp.
        send_pixel(10'h3FF, 0, 0, 0, 0);
        drop_valid();
        drain();

        // Randomized pixels, flags and gaps.
        for (int i = 0; i < 40; i++) begin
            logic [3:0] f;
            f = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) f = 4'h0;
            send_pixel(10'($urandom), f[0], f[1], f[2], f[3]);
            if ($urandom_range(0, 2) == 0) begin
                drop_valid();
                wait_cycles($urandom_range(0, 30));
            end
        end
        drop_valid();
        drain();

        // 100 back-to-back pixels.
        max_run = 0;
        for (int i = 0; i < 100; i++) begin
            send_pixel(10'(i), 0, 0, 0, 0);
            acc_t[i] = acc_cyc;
        end
        drop_valid();
        drain();
        chk("stream_run_words", max_run, 100);
        for (int i = 2; i < 100; i++) chk("ready_gap", acc_t[i] - acc_t[i-1], 12);

        // Reset mid pixel word while a second pixel is held.
        send_pixel(10'h0AA, 0, 0, 0, 0);
        send_pixel(10'h133, 0, 0, 0, 0);
        found = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge TxClk); #1;
            if (synced && pos == 6 && busy_w) found = 1;
        end
        chk("reset_point_found", found, 1);
        PixValid = 0;
        TxReset_n = 0;
        sb.delete();
        #1;
        chk("midrst_txd", TxD, 0);
        chk("midrst_busy", TxBusy, 0);
        chk("midrst_ready", PixReady, 0);
        chk("midrst_wordstart", TxWordStart, 0);
        wait_cycles(2);
        TxReset_n = 1;
        @(posedge TxClk); #1;
        chk("rerel_wordstart", TxWordStart, 1);
        chk("rerel_txd", TxD, 1);
        chk("rerel_busy", TxBusy, 0);
        busy_cycles = 0;
        wait_cycles(48);
        chk("rerel_busy_cycles", busy_cycles, 0);
        chk("rerel_queue", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
